layer_scheduler: RTL and testbench
==================================

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter MAX_LAYERS, default 16, maximum layers per run.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 24'hFFFFFF, watchdog limit per layer.
REQ-003 SHALL have port i_clk  in  1  clock.
REQ-004 SHALL have port i_rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_go  in  1  single-cycle run-request pulse.
REQ-006 SHALL have port i_num_layers  in  5  layer count for the run.
REQ-007 SHALL have port o_desc_addr  out  8  descriptor RAM word address, one-cycle read latency.
REQ-008 SHALL have port i_desc_data  in  32  descriptor RAM read data.
REQ-009 SHALL have port o_ctrl_addr  out  6  control RAM byte address (scheduler-side port), one-cycle read latency.
REQ-010 SHALL have port o_ctrl_we  out  1  control RAM write enable.
REQ-011 SHALL have port o_ctrl_data  out  32  control RAM write data.
REQ-012 SHALL have port i_ctrl_data  in  32  control RAM read data.
REQ-013 SHALL have port o_buf_sel  out  1  ping-pong image buffer select.
REQ-014 SHALL have port o_busy  out  1  run in progress.
REQ-015 SHALL have port o_layer  out  4  current layer index.
REQ-016 SHALL have port o_done  out  1  one-cycle pulse at run completion.
REQ-017 SHALL have port o_err  out  1  sticky watchdog error (present only with the macro of REQ-032).

Function
REQ-018 SHALL implement states IDLE, LOAD, ARM, WAIT, CLEAR, NEXT, FINISH.
REQ-019 IDLE: SHALL accept i_go; i_num_layers=0 -> FINISH, no RAM writes; values above MAX_LAYERS clamped to MAX_LAYERS; i_go outside IDLE ignored.
REQ-020 LOAD: SHALL read descriptor words k=1..15 of layer L at o_desc_addr = L*16+k, one per cycle, k ascending.
REQ-021 LOAD: SHALL write each word one cycle after its address, to o_ctrl_addr = 4*k; 16 cycles in LOAD.
REQ-022 ARM: SHALL write ctrl byte address 0 with descriptor word 0 with bit0 forced to 1 and bit1 forced to 0, in a single cycle.
REQ-023 WAIT: SHALL hold o_ctrl_addr=0 with o_ctrl_we=0 and discard the first read-data cycle.
REQ-024 WAIT: SHALL leave on the first subsequent cycle with i_ctrl_data[1]=1.
REQ-025 CLEAR: SHALL write 32'h0 to ctrl byte address 0, one cycle, so no stale done bit reaches the next layer.
REQ-026 NEXT: SHALL toggle o_buf_sel, increment o_layer, and go to LOAD if layers remain, else to FINISH.
REQ-027 FINISH: SHALL pulse o_done for one cycle and return to IDLE; o_layer and o_buf_sel hold until the next i_go.
REQ-028 i_go SHALL reset o_layer to 0; o_buf_sel SHALL keep its value across runs.
REQ-029 o_busy SHALL be 1 in every state except IDLE.
REQ-030 o_ctrl_we SHALL be asserted only in LOAD write cycles, ARM and CLEAR.

Reset
REQ-031 i_rst low SHALL force IDLE at any time, including mid-run, and drive all outputs and counters to 0 (o_err cleared).

Configuration
REQ-032 With SCHED_TIMEOUT_EN defined: a 24-bit counter SHALL count WAIT cycles; reaching TIMEOUT_CYC sets o_err, writes 32'h0 to ctrl address 0, and returns to IDLE without o_done; o_err clears on the next i_go.
REQ-033 Without SCHED_TIMEOUT_EN: no counter; o_err SHALL be tied 0; WAIT is unbounded.

Structure
REQ-034 Shared package SHALL hold the state encoding and control-word constants: CTRL=0, PARAM1=2, PARAM2=3, KERNEL_FIRST=4, KERNEL_LAST=12, bit indices START=0, DONE=1, CONV=2, MAXPOOL=4.
REQ-035 SHALL be a single module; no sub-module.

Verification
REQ-036 i_num_layers=0, i_go -> o_done pulses within 2 cycles; o_ctrl_we never asserted.
REQ-037 1 layer; descriptor words 0..15 = 32'h15, 32'h100+k -> ctrl addresses 4..60 receive 32'h101..32'h10F in order, then address 0 receives 32'h15; model sets bit1 after 50 cycles -> CLEAR writes 0; o_buf_sel toggles; o_done pulses.
REQ-038 3 layers -> descriptor base addresses 0/16/32; o_layer 0->1->2; o_buf_sel toggles 3 times; exactly one o_done.
REQ-039 Stale bit1=1 at address 0 before ARM -> WAIT ignores it: first-cycle discard, and ARM clears bit1.
REQ-040 Reset pulse mid-LOAD -> all outputs 0 immediately; a new i_go restarts the run at layer 0.
REQ-041 SCHED_TIMEOUT_EN with TIMEOUT_CYC=100, model never sets done -> o_err=1 after 100 WAIT cycles, address 0 written 0, no o_done.

Source files
------------

// File: rtl/layer_scheduler_pkg.sv
// layer_scheduler_pkg - state encoding and control-word layout shared by the
// layer scheduler and anything that talks to its control RAM.
package layer_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_WAIT,
        ST_CLEAR,
        ST_NEXT,
        ST_FINISH
    } sched_state_t;

    // Control RAM word indices (byte address = index * 4)
    localparam int CTRL         = 0;
    localparam int PARAM1       = 2;
    localparam int PARAM2       = 3;
    localparam int KERNEL_FIRST = 4;
    localparam int KERNEL_LAST  = 12;

    // Bit positions inside the CTRL word
    localparam int START   = 0;
    localparam int DONE    = 1;
    localparam int CONV    = 2;
    localparam int MAXPOOL = 4;

    localparam int DESC_WORDS = 16;

    // CTRL word as written at ARM: kick the engine, never carry a done flag in
    function automatic logic [31:0] arm_word(input logic [31:0] desc0);
        logic [31:0] w;
        w        = desc0;
        w[START] = 1'b1;
        w[DONE]  = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/layer_scheduler.sv
// layer_scheduler - walks an accelerator through up to MAX_LAYERS layers:
// copies each layer descriptor into the control RAM, starts the engine,
// waits for its done flag, clears it and swaps the ping-pong image buffer.
// Optional build macro: SCHED_TIMEOUT_EN adds a per-layer WAIT watchdog
// that aborts the run and raises the sticky o_err.
//
// state  | meaning
// IDLE   | waiting for i_go
// LOAD   | stream descriptor words 1..15 into control words 1..15
// ARM    | write CTRL word: descriptor word 0, START set, DONE cleared
// WAIT   | poll CTRL word for DONE (first read is stale, ignored)
// CLEAR  | zero CTRL word (also the watchdog abort write)
// NEXT   | advance layer, toggle image buffer
// FINISH | one-cycle o_done
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int          MAX_LAYERS  = 16,
    parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_go,
    input  logic [4:0]  i_num_layers,
    output logic [7:0]  o_desc_addr,
    input  logic [31:0] i_desc_data,
    output logic [5:0]  o_ctrl_addr,
    output logic        o_ctrl_we,
    output logic [31:0] o_ctrl_data,
    input  logic [31:0] i_ctrl_data,
    output logic        o_buf_sel,
    output logic        o_busy,
    output logic [3:0]  o_layer,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [4:0] MAX_L     = 5'(MAX_LAYERS);
    localparam logic [5:0] CTRL_BYTE = 6'(CTRL * 4);

    sched_state_t state, state_nxt;
    logic [4:0]   layer_cnt;
    logic [4:0]   num_lyr;
    logic [4:0]   go_layers;
    logic [3:0]   word_cnt;
    logic         first_wait;
    logic         buf_sel;
    logic         done_seen;
    logic         wd_hit;
    logic         abort_run;
    logic         unused_ctrl;

    assign go_layers   = (i_num_layers > MAX_L) ? MAX_L : i_num_layers;
    assign done_seen   = ~first_wait & i_ctrl_data[DONE];
    assign unused_ctrl = ^{i_ctrl_data[31:DONE+1], i_ctrl_data[START]};

    assign o_busy    = (state != ST_IDLE);
    assign o_layer   = layer_cnt[3:0];
    assign o_buf_sel = buf_sel;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and RAM-port decode
    always_comb begin
        state_nxt   = state;
        o_desc_addr = '0;
        o_ctrl_addr = '0;
        o_ctrl_we   = 1'b0;
        o_ctrl_data = '0;
        o_done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_go) state_nxt = (go_layers == 5'd0) ? ST_FINISH : ST_LOAD;
            end
            ST_LOAD: begin
                // word_cnt+1 wraps to 0 on the last cycle, prefetching word 0 for ARM
                o_desc_addr = {layer_cnt[3:0], word_cnt + 4'd1};
                o_ctrl_addr = {word_cnt, 2'b00};
                o_ctrl_we   = (word_cnt != 4'd0);
                o_ctrl_data = i_desc_data;
                if (word_cnt == 4'(DESC_WORDS - 1)) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                o_ctrl_addr = CTRL_BYTE;
                o_ctrl_we   = 1'b1;
                o_ctrl_data = arm_word(i_desc_data);
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                o_ctrl_addr = CTRL_BYTE;
                if (done_seen || wd_hit) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                o_ctrl_addr = CTRL_BYTE;
                o_ctrl_we   = 1'b1;
                state_nxt   = abort_run ? ST_IDLE : ST_NEXT;
            end
            ST_NEXT: begin
                state_nxt = ((layer_cnt + 5'd1) < num_lyr) ? ST_LOAD : ST_FINISH;
            end
            ST_FINISH: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Run bookkeeping: layer index, descriptor word counter, buffer select
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            layer_cnt  <= '0;
            num_lyr    <= '0;
            word_cnt   <= '0;
            first_wait <= 1'b0;
            buf_sel    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_go) begin
                        layer_cnt <= '0;
                        num_lyr   <= go_layers;
                        word_cnt  <= '0;
                    end
                end
                ST_LOAD: word_cnt   <= word_cnt + 4'd1;
                ST_ARM:  first_wait <= 1'b1;
                ST_WAIT: first_wait <= 1'b0;
                ST_NEXT: begin
                    layer_cnt <= layer_cnt + 5'd1;
                    buf_sel   <= ~buf_sel;
                end
                default: ;
            endcase
        end
    end

`ifdef SCHED_TIMEOUT_EN
    logic [23:0] wd_cnt;
    logic        err_q;

    // Hit on the TIMEOUT_CYC-th consecutive WAIT cycle
    assign wd_hit    = (wd_cnt == TIMEOUT_CYC - 24'd1);
    assign abort_run = err_q;
    assign o_err     = err_q;

    // Watchdog: count WAIT cycles, flag a layer that never reports done
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ST_WAIT) wd_cnt <= wd_cnt + 24'd1;
            else                  wd_cnt <= '0;
            if (state == ST_IDLE && i_go)
                err_q <= 1'b0;
            else if (state == ST_WAIT && !done_seen && wd_hit)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign wd_hit         = 1'b0;
    assign abort_run      = 1'b0;
    assign o_err          = 1'b0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler - randomized runs against a queue-based model of the
// expected control-RAM write stream, with RAM and accelerator models.
`timescale 1ns/1ps
module tb_layer_scheduler;

    typedef struct packed {
        logic [3:0]  layer;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_go = 1'b0;
    logic [4:0]  i_num_layers = '0;
    logic [7:0]  o_desc_addr;
    logic [31:0] i_desc_data;
    logic [5:0]  o_ctrl_addr;
    logic        o_ctrl_we;
    logic [31:0] o_ctrl_data;
    logic [31:0] i_ctrl_data;
    logic        o_buf_sel;
    logic        o_busy;
    logic [3:0]  o_layer;
    logic        o_done;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    layer_scheduler #(.MAX_LAYERS(16), .TIMEOUT_CYC(24'd100)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_go         (i_go),
        .i_num_layers (i_num_layers),
        .o_desc_addr  (o_desc_addr),
        .i_desc_data  (i_desc_data),
        .o_ctrl_addr  (o_ctrl_addr),
        .o_ctrl_we    (o_ctrl_we),
        .o_ctrl_data  (o_ctrl_data),
        .i_ctrl_data  (i_ctrl_data),
        .o_buf_sel    (o_buf_sel),
        .o_busy       (o_busy),
        .o_layer      (o_layer),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    // RAM and accelerator models
    logic [31:0] desc_mem [256];
    logic [31:0] ctrl_mem [16];
    logic        pre_req = 1'b0;
    logic [31:0] pre_val = '0;
    bit          acc_en = 1'b1;
    int          acc_delay = 5;
    int          acc_cnt = 0;
    bit          acc_done = 1'b0;
    int          cyc = 0;

    always @(posedge i_clk) begin
        cyc         <= cyc + 1;
        i_desc_data <= desc_mem[o_desc_addr];
        i_ctrl_data <= ctrl_mem[o_ctrl_addr[5:2]];
        if (pre_req) ctrl_mem[0] <= pre_val;
        if (o_ctrl_we) begin
            ctrl_mem[o_ctrl_addr[5:2]] <= o_ctrl_data;
            if (o_ctrl_addr == 6'd0 && o_ctrl_data[0]) begin
                acc_cnt  <= acc_delay;
                acc_done <= 1'b0;
            end
        end
        if (acc_cnt > 0) begin
            acc_cnt <= acc_cnt - 1;
            if (acc_cnt == 1 && acc_en) begin
                ctrl_mem[0] <= ctrl_mem[0] | 32'h2;
                acc_done    <= 1'b1;
            end
        end
    end

    // Monitor: capture control writes, done pulses, buffer toggles
    wr_t  got_q[$];
    int   got_cyc[$];
    int   done_cnt = 0;
    int   tog_cnt = 0;
    int   bad_clear = 0;
    logic prev_buf = 1'b0;

    always @(negedge i_clk) begin
        if (o_ctrl_we) begin
            got_q.push_back({o_layer, o_ctrl_addr, o_ctrl_data});
            got_cyc.push_back(cyc);
            if (o_ctrl_addr == 6'd0 && o_ctrl_data == 32'd0 && acc_en && !acc_done)
                bad_clear++;
        end
        if (o_done) done_cnt++;
        if (o_buf_sel !== prev_buf) tog_cnt++;
        prev_buf = o_buf_sel;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] v);
        pre_val = v;
        pre_req = 1'b1;
        tick();
        pre_req = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, o_busy, 0);
        check_val({tag, "_layer"}, o_layer, 0);
        check_val({tag, "_buf"}, o_buf_sel, 0);
        check_val({tag, "_we"}, o_ctrl_we, 0);
        check_val({tag, "_done"}, o_done, 0);
        check_val({tag, "_err"}, o_err, 0);
        check_val({tag, "_daddr"}, o_desc_addr, 0);
        check_val({tag, "_caddr"}, o_ctrl_addr, 0);
        check_val({tag, "_cdata"}, o_ctrl_data, 0);
    endtask

    // One complete run checked against the expected write stream
    task automatic do_run(input int num, input bit stale, input bit mid_go,
                          input int dly, input bit fixed);
        int   n, st, d0, t0, bc0, lat;
        logic b0;
        wr_t  e;
        wr_t  exp_q[$];
        n = (num > 16) ? 16 : num;
        for (int a = 0; a < 256; a++)
            desc_mem[a] = fixed ? ((a % 16 == 0) ? 32'h15 : 32'h100 + 32'(a % 16)) : $urandom;
        acc_en    = 1'b1;
        acc_delay = dly;
        preload(stale ? 32'h2 : 32'h0);
        for (int l = 0; l < n; l++) begin
            for (int k = 1; k < 16; k++) begin
                e.layer = 4'(l);
                e.addr  = 6'(4 * k);
                e.data  = desc_mem[l * 16 + k];
                exp_q.push_back(e);
            end
            e.layer = 4'(l);
            e.addr  = 6'd0;
            e.data  = (desc_mem[l * 16] | 32'h1) & ~32'h2;
            exp_q.push_back(e);
            e.data  = 32'h0;
            exp_q.push_back(e);
        end
        st  = got_q.size();
        d0  = done_cnt;
        t0  = tog_cnt;
        bc0 = bad_clear;
        b0  = o_buf_sel;
        i_num_layers = 5'(num);
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        lat = 0;
        for (int c = 0; c < 6000; c++) begin
            if (done_cnt != d0) break;
            if (c == 5) check_val("busy_run", o_busy, 1);
            if (mid_go && c == 20) begin
                i_num_layers = 5'd1;
                i_go = 1'b1;
            end else begin
                i_go = 1'b0;
            end
            tick();
            lat++;
        end
        i_go = 1'b0;
        check_val("done_seen", done_cnt != d0, 1);
        if (n == 0) check_val("zero_done_lat", lat <= 1, 1);
        repeat (3) tick();
        check_val("done_once", done_cnt - d0, 1);
        check_val("busy_end", o_busy, 0);
        check_val("wr_count", got_q.size() - st, exp_q.size());
        for (int i = 0; i < exp_q.size() && st + i < got_q.size(); i++)
            check_val("wr", got_q[st + i], exp_q[i]);
        check_val("buf_toggles", tog_cnt - t0, n);
        check_val("buf_final", o_buf_sel, b0 ^ n[0]);
        check_val("layer_final", o_layer, n % 16);
        check_val("early_clear", bad_clear - bc0, 0);
        check_val("err_clear", o_err, 0);
    endtask

    // Reset asserted while descriptors are streaming
    task automatic reset_mid_load();
        int st;
        for (int a = 0; a < 256; a++) desc_mem[a] = $urandom;
        acc_en    = 1'b1;
        acc_delay = 10;
        preload(32'h0);
        st = got_q.size();
        i_num_layers = 5'd2;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        for (int c = 0; c < 100 && got_q.size() - st < 6; c++) tick();
        check_val("mid_load_busy", o_busy, 1);
        #2;
        i_rst = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        repeat (2) tick();
        i_rst = 1'b1;
        tick();
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic timeout_run();
        int st, d0;
        acc_en = 1'b0;
        preload(32'h0);
        st = got_q.size();
        d0 = done_cnt;
        i_num_layers = 5'd1;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        for (int c = 0; c < 1000 && o_busy; c++) tick();
        check_val("to_idle", o_busy, 0);
        check_val("to_err", o_err, 1);
        check_val("to_no_done", done_cnt - d0, 0);
        check_val("to_wr_count", got_q.size() - st, 17);
        if (got_q.size() - st == 17) begin
            check_val("to_zero_wr", got_q[st + 16], 42'd0);
            check_val("to_wait_len", got_cyc[st + 16] - got_cyc[st + 15], 101);
        end
        repeat (3) tick();
        check_val("to_err_sticky", o_err, 1);
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        int num;
        repeat (3) tick();
        check_idle_outputs("reset");
        i_rst = 1'b1;
        tick();

        do_run(0, 1'b0, 1'b0, 5, 1'b0);
        do_run(1, 1'b0, 1'b0, 50, 1'b1);
        reset_mid_load();
        do_run(1, 1'b0, 1'b0, 7, 1'b0);
        do_run(3, 1'b1, 1'b0, 12, 1'b0);
        do_run(2, 1'b1, 1'b1, 3, 1'b0);
        for (int r = 0; r < 6; r++) begin
            if (r == 0)      num = 20;
            else if (r == 1) num = 16;
            else             num = $urandom_range(0, 9);
            do_run(num, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(2, 40), 1'b0);
        end
`ifdef SCHED_TIMEOUT_EN
        timeout_run();
        do_run(1, 1'b0, 1'b0, 4, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
